// File: rtl/router_trace_buffer_pkg.sv
// Shared definitions for the router trace buffer: FSM states, width helper and
// entry field offsets for the packed {src, ts, trace} layout.
package router_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ts_lsb(input int tracew);
    return tracew;
  endfunction

  function automatic int src_lsb(input int tracew, input int tsw);
    return tracew + tsw;
  endfunction

endpackage

// File: rtl/router_trace_buffer_arbiter.sv
// Round-robin arbiter over SRC_NUM trigger sources: one-hot grant, grant index
// and request popcount. The rotation pointer advances past the winner on grant.
module trace_src_arbiter
  import router_trace_buffer_pkg::*;
#(
  parameter int SRC_NUM = 2,
  parameter int SRCw    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SRC_NUM-1:0] req,
  output logic [SRC_NUM-1:0] gnt,
  output logic [SRCw-1:0]    gnt_idx,
  output logic               gnt_valid,
  output logic [SRCw:0]      req_cnt
);

  localparam int CW = SRCw + 1;

  logic [SRCw-1:0] rr_q, rr_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    req_cnt   = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      req_cnt = req_cnt + CW'(req[i]);
    end
    // Scan from the farthest offset down so the closest requester to rr_q wins.
    for (int off = SRC_NUM - 1; off >= 0; off--) begin
      int idx;
      idx = int'(rr_q) + off;
      if (idx >= SRC_NUM) idx = idx - SRC_NUM;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRCw'(idx);
      end
    end
    gnt[gnt_idx] = gnt_valid;

    rr_d = rr_q;
    if (gnt_valid) begin
      rr_d = (int'(gnt_idx) == SRC_NUM - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/router_trace_buffer.sv
// DfD trace capture: round-robin trigger selection, timestamped circular buffer
// with stop condition and post-stop count, frozen and drained after capture.
module router_trace_buffer
  import router_trace_buffer_pkg::*;
#(
  parameter int SRC_NUM = 2,
  parameter int TRACEw  = 32,
  parameter int DEPTH   = 16,
  parameter int TSw     = 16,
  parameter int DROPw   = 8,
  parameter int SRCw    = (SRC_NUM > 1) ? log2_ceil(SRC_NUM) : 1,
  parameter int CNTw    = log2_ceil(DEPTH) + 1,
  parameter int ENTw    = SRCw + TSw + TRACEw
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SRC_NUM-1:0]        trigger_all,
  input  logic [SRC_NUM*TRACEw-1:0] trace_all,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [SRC_NUM-1:0]        cfg_stop_mask,
  input  logic [CNTw-1:0]           cfg_post_cnt,
  input  logic                      rd_en,
  output logic [ENTw-1:0]           rd_data,
  output logic                      rd_valid,
  output logic                      trigger,
  output logic [TRACEw-1:0]         trace,
  output logic [1:0]                state,
  output logic [CNTw-1:0]           count,
  output logic [DROPw-1:0]          drop_cnt,
  output logic                      done
);

  localparam int PTRw    = CNTw - 1;
  localparam int DSW     = DROPw + SRCw + 1;
  localparam int TS_LSB  = ts_lsb(TRACEw);
  localparam int SRC_LSB = src_lsb(TRACEw, TSw);

  logic [SRC_NUM-1:0] gnt;
  logic [SRCw-1:0]    gnt_idx;
  logic               gnt_valid;
  logic [SRCw:0]      req_cnt;

  trace_src_arbiter #(
    .SRC_NUM (SRC_NUM),
    .SRCw    (SRCw)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (trigger_all),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .req_cnt   (req_cnt)
  );

  trace_state_e       state_q, state_d;
  logic [PTRw-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTw-1:0]    count_q, count_d, remaining_q, remaining_d;
  logic [DROPw-1:0]   drop_q, drop_d;
  logic [ENTw-1:0]    rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               trigger_q, trigger_d;
  logic [TRACEw-1:0]  trace_q, trace_d;
  logic [TSw-1:0]     ts_q, ts_d;

  logic [ENTw-1:0]    mem [DEPTH];
  logic               mem_we;
  logic [ENTw-1:0]    wr_entry;
  logic [CNTw-1:0]    post_load;
  logic [DSW-1:0]     drop_sum;
  logic               capturing;

  always_comb begin
    trigger_d = |trigger_all;
    trace_d   = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (gnt[i]) trace_d = trace_all[i*TRACEw +: TRACEw];
    end
    ts_d     = ts_q + 1'b1;
    wr_entry = '0;
    wr_entry[SRC_LSB +: SRCw] = gnt_idx;
    wr_entry[TS_LSB +: TSw]   = ts_q;
    wr_entry[0 +: TRACEw]     = trace_d;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    drop_d      = drop_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    mem_we      = 1'b0;
    post_load   = (cfg_post_cnt > CNTw'(DEPTH - 1)) ? CNTw'(DEPTH - 1) : cfg_post_cnt;
    drop_sum    = DSW'(drop_q) + DSW'(req_cnt) - DSW'(1);
    capturing   = (state_q == ST_ARMED) || (state_q == ST_POST);

    if (abort) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      remaining_d = '0;
    end else begin
      if (capturing && req_cnt > (SRCw+1)'(1)) begin
        drop_d = (drop_sum > DSW'({DROPw{1'b1}})) ? '1 : drop_sum[DROPw-1:0];
      end
      // A full buffer keeps count at DEPTH and drops the oldest entry instead.
      if (capturing && gnt_valid) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q == CNTw'(DEPTH)) rd_ptr_d = rd_ptr_q + 1'b1;
        else                         count_d  = count_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            remaining_d = '0;
            drop_d      = '0;
          end
        end
        ST_ARMED: begin
          if (gnt_valid && cfg_stop_mask[gnt_idx]) begin
            remaining_d = post_load;
            state_d     = (post_load == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (gnt_valid) begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == CNTw'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            remaining_d = '0;
            drop_d      = '0;
          end else if (rd_en && count_q != '0) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d    = count_q - 1'b1;
            if (count_q == CNTw'(1)) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      drop_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      trigger_q   <= 1'b0;
      trace_q     <= '0;
      ts_q        <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      drop_q      <= drop_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      trigger_q   <= trigger_d;
      trace_q     <= trace_d;
      ts_q        <= ts_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= wr_entry;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign trigger  = trigger_q;
  assign trace    = trace_q;
  assign state    = state_q;
  assign count    = count_q;
  assign drop_cnt = drop_q;
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_router_trace_buffer.sv
// Directed bench for router_trace_buffer: expected entries are queued when
// triggers are driven and compared as the buffer is drained.
module tb_router_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  trigger_all;
  logic [63:0] trace_all;
  logic        arm, abort, rd_en;
  logic [1:0]  cfg_stop_mask;
  logic [4:0]  cfg_post_cnt;
  logic [48:0] rd_data;
  logic        rd_valid, trigger, done;
  logic [31:0] trace;
  logic [1:0]  state;
  logic [4:0]  count;
  logic [7:0]  drop_cnt;

  logic [3:0]   trig4;
  logic [127:0] trace4;
  logic         arm4;
  logic [3:0]   mask4;
  logic [49:0]  rd_data4;
  logic         rd_valid4, trigger4, done4;
  logic [31:0]  trace_o4;
  logic [1:0]   state4;
  logic [4:0]   count4;
  logic [7:0]   drop4;

  int checks = 0;
  int errors = 0;
  logic [15:0] tb_ts;
  logic [48:0] sb[$];

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 16'd1;
  end

  router_trace_buffer dut (
    .clk(clk), .reset(reset), .trigger_all(trigger_all), .trace_all(trace_all),
    .arm(arm), .abort(abort), .cfg_stop_mask(cfg_stop_mask), .cfg_post_cnt(cfg_post_cnt),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .trigger(trigger),
    .trace(trace), .state(state), .count(count), .drop_cnt(drop_cnt), .done(done)
  );

  router_trace_buffer #(.SRC_NUM(4)) dut4 (
    .clk(clk), .reset(reset), .trigger_all(trig4), .trace_all(trace4),
    .arm(arm4), .abort(1'b0), .cfg_stop_mask(mask4), .cfg_post_cnt(5'd0),
    .rd_en(1'b0), .rd_data(rd_data4), .rd_valid(rd_valid4), .trigger(trigger4),
    .trace(trace_o4), .state(state4), .count(count4), .drop_cnt(drop4), .done(done4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one trigger cycle; exp_src is the source the arbiter must grant.
  task automatic fire(input logic [1:0] trig, input int exp_src, input bit cap);
    logic [31:0] w0, w1, wexp;
    w0 = $urandom;
    w1 = $urandom;
    wexp = (exp_src == 1) ? w1 : w0;
    trigger_all = trig;
    trace_all   = {w1, w0};
    if (cap) sb.push_back({exp_src[0], tb_ts, wexp});
    tick();
    trigger_all = '0;
    trace_all   = '0;
    check("trigger_out", 64'(trigger), 64'(|trig));
    check("trace_out", 64'(trace), (trig != 2'b00) ? 64'(wexp) : 64'd0);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_n(input int n);
    logic [48:0] exp;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      check("rd_valid", 64'(rd_valid), 64'd1);
      check("rd_data", 64'(rd_data), 64'(exp));
    end
    rd_en = 1'b0;
    tick();
    check("rd_valid_pulse", 64'(rd_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    trigger_all = '0; trace_all = '0; arm = 0; abort = 0; rd_en = 0;
    cfg_stop_mask = '0; cfg_post_cnt = '0;
    trig4 = '0; trace4 = '0; arm4 = 0; mask4 = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_trace", 64'(trace), 64'd0);

    // Single source with two post-stop events.
    cfg_stop_mask = 2'b01;
    cfg_post_cnt  = 5'd2;
    pulse_arm();
    check("armed", 64'(state), 64'd1);
    fire(2'b01, 0, 1);
    check("post_after_stop", 64'(state), 64'd2);
    check("latency_count", 64'(count), 64'd1);
    fire(2'b01, 0, 1);
    fire(2'b01, 0, 1);
    check("single_done_state", 64'(state), 64'd3);
    check("single_done_flag", 64'(done), 64'd1);
    check("single_count", 64'(count), 64'd3);
    read_n(3);
    check("single_idle", 64'(state), 64'd0);
    check("single_empty", 64'(count), 64'd0);

    // Round-robin: rotate pointer back to src0 while idle, then both fire.
    cfg_stop_mask = 2'b00;
    fire(2'b10, 1, 0);
    check("idle_no_capture", 64'(count), 64'd0);
    pulse_arm();
    fire(2'b11, 0, 1);
    fire(2'b11, 1, 1);
    fire(2'b11, 0, 1);
    fire(2'b11, 1, 1);
    check("rr_drop", 64'(drop_cnt), 64'd4);
    cfg_stop_mask = 2'b01;
    cfg_post_cnt  = 5'd0;
    fire(2'b01, 0, 1);
    check("rr_done", 64'(state), 64'd3);
    check("rr_count", 64'(count), 64'd5);
    read_n(5);
    check("rr_drop_kept", 64'(drop_cnt), 64'd4);

    // Wrap: 20 events into 16 entries, then a stop with no post events.
    pulse_arm();
    for (int i = 0; i < 20; i++) fire(2'b10, 1, 1);
    fire(2'b01, 0, 1);
    check("wrap_done", 64'(state), 64'd3);
    check("wrap_count", 64'(count), 64'd16);
    while (sb.size() > 16) void'(sb.pop_front());
    read_n(16);

    // Post count clamps to DEPTH-1.
    cfg_post_cnt = 5'd20;
    pulse_arm();
    fire(2'b01, 0, 0);
    for (int i = 0; i < 14; i++) fire(2'b01, 0, 0);
    check("clamp_still_post", 64'(state), 64'd2);
    fire(2'b01, 0, 0);
    check("clamp_done", 64'(state), 64'd3);
    check("clamp_count", 64'(count), 64'd16);

    // Re-arm from DONE discards contents; abort in POST beats arm.
    pulse_arm();
    check("rearm_state", 64'(state), 64'd1);
    check("rearm_count", 64'(count), 64'd0);
    cfg_post_cnt = 5'd3;
    fire(2'b01, 0, 0);
    fire(2'b11, 1, 0);
    check("post_drop", 64'(drop_cnt), 64'd1);
    check("post_count", 64'(count), 64'd2);
    abort = 1'b1;
    arm   = 1'b1;
    tick();
    abort = 1'b0;
    arm   = 1'b0;
    check("abort_state", 64'(state), 64'd0);
    check("abort_count", 64'(count), 64'd0);
    check("abort_drop_kept", 64'(drop_cnt), 64'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd_empty_valid", 64'(rd_valid), 64'd0);

    // Reset while DONE.
    cfg_post_cnt = 5'd0;
    pulse_arm();
    fire(2'b01, 0, 0);
    check("pre_reset_done", 64'(state), 64'd3);
    reset = 1'b1;
    #1;
    check("reset_state", 64'(state), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_trigger", 64'(trigger), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_drop", 64'(drop_cnt), 64'd0);
    tick();
    reset = 1'b0;

    // Drop counter saturation with four sources.
    arm4 = 1'b1;
    tick();
    arm4 = 1'b0;
    trig4 = 4'hF;
    trace4 = {4{32'h1234_5678}};
    tick();
    check("sat_first", 64'(drop4), 64'd3);
    repeat (99) tick();
    trig4 = '0;
    check("sat_drop", 64'(drop4), 64'd255);
    check("sat_count", 64'(count4), 64'd16);
    check("sat_state", 64'(state4), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
